aes_add_round_key: RTL and testbench
====================================

Name: aes_add_round_key

Overview:
- Stage directly downstream of the AES column-mixing stage.
- XORs each 128-bit state beat with the current AES-128 round key and registers the result.
- The round keys are generated on the fly by an iterative key schedule, one round key per accepted beat.
- Valid/ready handshake on both sides, so the stage can be dropped into an iterative round datapath.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported. Round keys 0..NR give NR+1 beats per block.
- BW, 128, state/key width; fixed at 128.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_load  input  1  one-cycle pulse; captures key_in as cipher key.
- key_in  input  128  cipher key. Byte 0 is at [7:0]; word j is at [32j+31:32j].
- in_valid  input  1  state beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  128  state; byte k at [8k+7:8k], same byte order as the column-mixing stage.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  in_data XOR round key.
- out_round  output  4  round index (0..NR) of the key used for out_data.
- out_last  output  1  high when out_round==NR.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_round=0, out_last=0; state=IDLE; stored key and current key=0; round_cnt=0; rcon=8'h01.
- in_ready is combinational: (state==RUN) && !key_load && (!out_valid || out_ready).
- FSM IDLE: in_ready=0. key_load does the following, then goes to RUN:
  - cipher_key <= key_in; rk <= key_in; round_cnt <= 0; rcon <= 8'h01.
- FSM RUN: a beat is accepted when in_valid && in_ready. On acceptance:
  - out_data <= in_data ^ rk; out_round <= round_cnt; out_last <= (round_cnt==NR); out_valid <= 1.
  - If round_cnt < NR: rk <= next_key(rk, rcon); rcon <= xtime(rcon); round_cnt++.
  - If round_cnt == NR (wrap): rk <= cipher_key; rcon <= 8'h01; round_cnt <= 0. The next block then starts without a reload.
- next_key: t = SubWord(RotWord(w3)) ^ {24'h0, rcon}.
  - RotWord(b0,b1,b2,b3) = (b1,b2,b3,b0), with byte 0 in the low bits.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. xtime is (x<<1) ^ (x[7] ? 8'h1B : 0).
- Latency: 1 cycle from acceptance to out_valid. Full throughput is 1 beat/cycle when out_ready stays high.
- Output handshake: out_valid clears on out_valid && out_ready with no new acceptance in that cycle. While out_valid && !out_ready, out_data/out_round/out_last hold stable.
- key_load in RUN: reloads as above and aborts the current block. in_ready is 0 in that cycle, so no beat is accepted. A pending output is unaffected and still delivered with its old out_round.
- key_load and in_valid in the same cycle: key_load wins; the beat stays pending upstream.
- Asynchronous reset mid-block: all state returns to reset values immediately and the key is lost. IDLE requires a new key_load.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- Defined:
  - Adds input key_clear (1 bit).
  - key_clear pulse in any state: cipher_key, rk and out_data <= 0; out_valid <= 0; round_cnt <= 0; state <= IDLE.
  - key_clear has priority over key_load and over beat acceptance in the same cycle.
- Undefined: the port is absent; keys are cleared only by rst_n.

Decomposition:
- Package aes_pkg:
  - constants AES_BW=128, AES_NR=10, RCON_INIT=8'h01, XTIME_POLY=8'h1B.
  - typedef aes_state_t (logic [127:0]).
  - typedef aes_word_t (logic [31:0]).
  - enum ark_state_e {IDLE, RUN}.
  - function xtime8.
- Sub-module aes_sbox: combinational 8-bit S-box. Instantiated 4x for SubWord; the same module is reused by the SubBytes stage.

Test Plan:
- Reset then key_load with key_in = FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c (0x2b at [7:0]); beat in_data=0 -> out_data = key, out_round=0, out_last=0, one cycle later.
- Continue with in_data=0 beats, out_ready=1 -> round 1 out_data = a0fafe17 88542cb1 23a33939 2a6c7605; round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with out_last=1.
- 12th consecutive zero beat after the round-10 beat -> out_data equals the cipher key again, out_round=0 (wrap without reload).
- Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data stable, no beat lost. Release -> next beat uses the following round key.
- Assert key_load with a new key after round 4 while in_valid=1 -> that beat is not accepted. Next accepted beat: out_round=0, new key applied.
- Drop rst_n mid-block (round 6) -> out_valid=0 immediately, in_ready=0 until key_load. With AES_KEY_ZEROIZE_EN, key_clear produces the same result.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, types and the GF(2^8) doubling helper.
package aes_pkg;
  localparam int AES_BW = 128;
  localparam int AES_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;
  typedef logic [AES_BW-1:0] aes_state_t;
  typedef logic [31:0] aes_word_t;
  typedef enum logic {IDLE, RUN} ark_state_e;
  function automatic logic [7:0] xtime8(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_add_round_key_if.sv
// aes_add_round_key_if: key load plus valid/ready state-in and result-out channels.
interface aes_add_round_key_if;
  import aes_pkg::*;
  logic       key_load;
  aes_state_t key_in;
  logic       in_valid;
  logic       in_ready;
  aes_state_t in_data;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_data;
  logic [3:0] out_round;
  logic       out_last;
  modport master (
    output key_load, key_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_round, out_last
  );
  modport slave (
    input  key_load, key_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_round, out_last
  );
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box; table entry for byte 0x00 sits in the top byte.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign out_byte = SBOX[~in_byte];
endmodule

// File: rtl/aes_add_round_key.sv
// aes_add_round_key: XORs each state beat with an on-the-fly AES-128 round key and registers it.
// Optional AES_KEY_ZEROIZE_EN adds a key_clear input that wipes the key material.
module aes_add_round_key
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int BW = AES_BW
) (
  input logic clk,
  input logic rst_n,
`ifdef AES_KEY_ZEROIZE_EN
  input logic key_clear,
`endif
  aes_add_round_key_if.slave bus
);
  localparam logic [3:0] LAST = 4'(NR);
  ark_state_e state_q, state_d;
  logic [BW-1:0] cipher_key_q, cipher_key_d, rk_q, rk_d, out_data_q, out_data_d;
  logic [3:0] round_cnt_q, round_cnt_d, out_round_q, out_round_d;
  logic [7:0] rcon_q, rcon_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic clr, accept, wrap;
  aes_word_t rot, sub, t, n0, n1, n2, n3;
`ifdef AES_KEY_ZEROIZE_EN
  assign clr = key_clear;
`else
  assign clr = 1'b0;
`endif
  // SubWord(RotWord(w3)); byte 0 lives in the low bits
  assign rot = {rk_q[103:96], rk_q[127:104]};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.in_byte(rot[8*i +: 8]), .out_byte(sub[8*i +: 8]));
  end
  assign t  = sub ^ {24'h0, rcon_q};
  assign n0 = rk_q[31:0] ^ t;
  assign n1 = rk_q[63:32] ^ n0;
  assign n2 = rk_q[95:64] ^ n1;
  assign n3 = rk_q[127:96] ^ n2;
  assign wrap = round_cnt_q == LAST;
  assign bus.in_ready = (state_q == RUN) && !bus.key_load && !clr && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d      = state_q;
    cipher_key_d = cipher_key_q;
    rk_d         = rk_q;
    round_cnt_d  = round_cnt_q;
    rcon_d       = rcon_q;
    out_data_d   = out_data_q;
    out_round_d  = out_round_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    if (clr) begin
      state_d      = IDLE;
      cipher_key_d = '0;
      rk_d         = '0;
      out_data_d   = '0;
      out_valid_d  = 1'b0;
      round_cnt_d  = '0;
      rcon_d       = RCON_INIT;
    end else if (bus.key_load) begin
      state_d      = RUN;
      cipher_key_d = bus.key_in;
      rk_d         = bus.key_in;
      round_cnt_d  = '0;
      rcon_d       = RCON_INIT;
    end else if (accept) begin
      out_data_d  = bus.in_data ^ rk_q;
      out_round_d = round_cnt_q;
      out_last_d  = wrap;
      out_valid_d = 1'b1;
      rk_d        = wrap ? cipher_key_q : {n3, n2, n1, n0};
      rcon_d      = wrap ? RCON_INIT : xtime8(rcon_q);
      round_cnt_d = wrap ? 4'd0 : round_cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cipher_key_q <= '0;
      rk_q         <= '0;
      round_cnt_q  <= '0;
      rcon_q       <= RCON_INIT;
      out_data_q   <= '0;
      out_round_q  <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cipher_key_q <= cipher_key_d;
      rk_q         <= rk_d;
      round_cnt_q  <= round_cnt_d;
      rcon_q       <= rcon_d;
      out_data_q   <= out_data_d;
      out_round_q  <= out_round_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_round = out_round_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_aes_add_round_key.sv
// tb_aes_add_round_key: scoreboard bench using FIPS-197 key-expansion vectors.
module tb_aes_add_round_key;
  import aes_pkg::*;
  typedef struct packed {
    aes_state_t data;
    logic [3:0] round;
    logic       last;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
  logic key_clear = 1'b0;
`endif
  aes_add_round_key_if bus();
  aes_add_round_key dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef AES_KEY_ZEROIZE_EN
    .key_clear(key_clear),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  aes_state_t rka [0:10];
  aes_state_t kb, kb1;
  localparam aes_state_t D1 = 128'h00112233445566778899aabbccddeeff;
  localparam aes_state_t D2 = 128'hffffffffffffffffffffffffffffffff;
  localparam aes_state_t D3 = 128'h0123456789abcdeffedcba9876543210;
  localparam aes_state_t D4 = 128'h80000000000000000000000000000001;
  localparam aes_state_t D5 = 128'h3243f6a8885a308d313198a2e0370734;
  function automatic aes_state_t bswap(input aes_state_t x);
    aes_state_t y;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = x[8*(15-k) +: 8];
    return y;
  endfunction
  task automatic chk(input string nm, input aes_state_t act, input aes_state_t req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask
  task automatic load(input aes_state_t k);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    @(posedge clk); #1;
    bus.key_load = 1'b0;
  endtask
  task automatic send(input aes_state_t d, input int r, input aes_state_t k);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk($sformatf("accept_r%0d", r), 128'(acc), 128'(1));
    if (acc) sb.push_back('{d ^ k, 4'(r), r == 10});
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got round %0d data %h, required no output", bus.out_round, bus.out_data);
        end else begin
          e = sb.pop_front();
          chk($sformatf("out_data_r%0d", e.round), bus.out_data, e.data);
          chk($sformatf("out_round_r%0d", e.round), 128'(bus.out_round), 128'(e.round));
          chk($sformatf("out_last_r%0d", e.round), 128'(bus.out_last), 128'(e.last));
        end
      end
    end
  end
  initial begin
    rka[0]  = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rka[1]  = bswap(128'ha0fafe1788542cb123a339392a6c7605);
    rka[2]  = bswap(128'hf2c295f27a96b9435935807a7359f67f);
    rka[3]  = bswap(128'h3d80477d4716fe3e1e237e446d7a883b);
    rka[4]  = bswap(128'hef44a541a8525b7fb671253bdb0bad00);
    rka[5]  = bswap(128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    rka[6]  = bswap(128'h6d88a37a110b3efddbf98641ca0093fd);
    rka[7]  = bswap(128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
    rka[8]  = bswap(128'head27321b58dbad2312bf5607f8d292f);
    rka[9]  = bswap(128'hac7766f319fadc2128d12941575c006e);
    rka[10] = bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    kb  = bswap(128'h000102030405060708090a0b0c0d0e0f);
    kb1 = bswap(128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    bus.key_load = 1'b0; bus.key_in = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_round", 128'(bus.out_round), 128'(0));
    chk("rst_out_last", 128'(bus.out_last), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // full block of zero beats, then a wrap beat without reload
    load(rka[0]);
    for (int r = 0; r <= 10; r++) send('0, r, rka[r]);
    send('0, 0, rka[0]);
    // stall the wrap output for three cycles with a beat waiting
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = D1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
      chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_out_data", bus.out_data, rka[0]);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(D1, 1, rka[1]);
    send(D2, 2, rka[2]);
    send(D3, 3, rka[3]);
    send(D4, 4, rka[4]);
    // key_load collides with a valid beat: key wins, beat stays pending
    bus.key_load = 1'b1;
    bus.key_in   = kb;
    bus.in_valid = 1'b1;
    bus.in_data  = D5;
    @(negedge clk);
    chk("keyload_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    bus.key_load = 1'b0;
    send(D5, 0, kb);
    send('0, 1, kb1);
    // asynchronous reset with round 6 output pending
    load(rka[0]);
    for (int r = 0; r <= 5; r++) send(D3, r, rka[r]);
    send(D2, 6, rka[6]);
    bus.out_ready = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_out_data", bus.out_data, '0);
    chk("arst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("arst_pending", 128'(sb.size()), 128'(1));
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("postrst_in_ready", 128'(bus.in_ready), 128'(0));
      chk("postrst_out_valid", 128'(bus.out_valid), 128'(0));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    load(rka[0]);
    send(D1, 0, rka[0]);
    send(D1, 1, rka[1]);
`ifdef AES_KEY_ZEROIZE_EN
    send(D4, 2, rka[2]);
    bus.out_ready = 1'b0;
    key_clear     = 1'b1;
    bus.key_load  = 1'b1;
    bus.key_in    = kb;
    bus.in_valid  = 1'b1;
    bus.in_data   = D5;
    @(negedge clk);
    chk("clr_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    key_clear    = 1'b0;
    bus.key_load = 1'b0;
    chk("clr_pending", 128'(sb.size()), 128'(1));
    sb.delete();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("clr_out_valid", 128'(bus.out_valid), 128'(0));
    chk("clr_out_data", bus.out_data, '0);
    chk("clr_idle_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    load(rka[0]);
    send(D5, 0, rka[0]);
`endif
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
